axi_slv_mem: RTL and testbench
==============================

# axi_slv_mem

Synthesizable AXI4 memory slave that answers the master agent's five channels. It sits behind the master interface as the DUT-side responder, so master-driven sequences run against real RTL. Write and read paths are independent state machines sharing one word-addressed memory array. FIXED, INCR and (optionally) WRAP bursts are supported, with OKAY/SLVERR responses.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width (32 or 64)
- ID_WIDTH, 8, AXI ID width for awid/bid/arid/rid
- MEM_DEPTH, 1024, number of DATA_WIDTH words in the array
- aclk  in  1  clock
- aresetn  in  1  reset; one clock, asynchronous, active-low
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address payload
- awvalid in 1, awready out 1  write address handshake
- wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data payload
- wvalid in 1, wready out 1  write data handshake
- bid/bresp  out  ID_WIDTH/2  write response
- bvalid out 1, bready in 1  write response handshake
- arid/araddr/arlen/arsize/arburst  in  as AW  read address payload
- arvalid in 1, arready out 1  read address handshake
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data payload
- rvalid out 1, rready in 1  read data handshake

## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. W_IDLE: awready=1; AW handshake latches id/addr/len/size/burst, clears beat count and error flag, goes to W_DATA.
- W_DATA: wready=1. Each W handshake writes the byte lanes enabled by wstrb into mem[addr >> log2(DATA_WIDTH/8)], then advances addr. Move to W_RESP when beat count == len.
- W_RESP: bvalid=1, bid=latched id, bresp=SLVERR if the error flag is set, else OKAY. Hold until bready, then go to W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE. R_IDLE: arready=1; AR handshake latches the payload. R_DATA: rvalid=1, rid=latched id, rlast=(count==len). Advance on rready. Return to R_IDLE after the rlast handshake.
- Next address: FIXED keeps the address. INCR adds 1<<size. WRAP (see Configuration) wraps within (len+1)<<size aligned bytes.
- Error conditions set SLVERR for the whole burst:
  - size > log2(DATA_WIDTH/8)
  - burst==2'b11
  - any beat word index >= MEM_DEPTH
  - wlast mismatch (asserted before the final beat, or absent on it)
- Erroring write beats do not update memory. Erroring read beats return rdata=0 and rresp=SLVERR.
- Burst termination is always by count, never by wlast.
- Simultaneous write and read to the same word in the same cycle: the read returns the old data.

## Timing
- Reset values (aresetn low, asynchronous): awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0. Both FSMs go to IDLE.
- Memory contents are retained across reset.
- awready and arready rise on the first aclk edge after aresetn is released.
- All outputs are registered.
- After an AW handshake at edge N, wready=1 from N+1. After the last W handshake at edge M, bvalid=1 from M+1.
- After an AR handshake at edge N, rvalid=1 from N+1 with valid rdata. Back-to-back beats follow while rready=1 (one beat per cycle).
- Reset asserted mid-burst aborts the burst. Partial writes already committed stay in memory; no B or R is issued for it.
- valid signals never drop without a handshake. Payload is stable while valid && !ready.

## Configuration
- AXI_SLV_WRAP_EN defined: WRAP bursts are supported. len must be 1, 3, 7 or 15, and the start address must be aligned to 1<<size; otherwise SLVERR.
- AXI_SLV_WRAP_EN undefined: WRAP is treated as an error burst. It completes all len+1 beats with SLVERR, writes nothing, and reads return 0.

## Structure
- Package axi_slv_pkg holds:
  - burst encodings FIXED=0, INCR=1, WRAP=2
  - resp constants OKAY=0, SLVERR=2
  - enums w_state_t and r_state_t
- Sub-module axi_slv_addr_gen is combinational next-address and error-check logic (addr, len, size, burst -> next_addr, err). It is instantiated once per channel.

## Test plan
- INCR write, awaddr=0x10, len=3, size=2, data 0xA0..0xA3, wstrb=0xF. Then INCR read at the same address: rdata 0xA0..0xA3, rlast on beat 3, both resp OKAY, bid/rid echo 0x5.
- FIXED write len=1 with wstrb 0x1 then 0x2 to 0x40 over 0x0 (data 0x11, 0x2200): read at 0x40 returns 0x00002211.
- WRAP write with AXI_SLV_WRAP_EN, awaddr=0x08, len=3, size=2: data lands at 0x08, 0x0C, 0x00, 0x04. Without the macro: bresp=SLVERR and memory is unchanged.
- Read with araddr=MEM_DEPTH*4, len=1: two beats, rdata=0, rresp=SLVERR, rlast on beat 1.
- Write len=3 with wlast on beat 1: four beats accepted, bresp=SLVERR, no memory change. rready held low 5 cycles mid-read: rvalid/rdata stay stable.
- aresetn pulsed low during W_DATA beat 2: all valid/ready outputs are 0 immediately. The next AW is accepted one edge after release.

Source files
------------

// File: rtl/axi_slv_pkg.sv
// Shared encodings and state types for the AXI4 memory slave.
package axi_slv_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi_slv_addr_gen.sv
// Combinational next-beat address and burst-level error check.
// WRAP bursts are legal only when AXI_SLV_WRAP_EN is defined.
module axi_slv_addr_gen
    import axi_slv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_len,
    input  logic [2:0]            i_size,
    input  logic [1:0]            i_burst,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic                  o_err
);

    localparam int unsigned LSB = $clog2(DATA_WIDTH / 8);
    localparam int unsigned XW  = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_total;
    logic [ADDR_WIDTH-1:0] w_mask;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [XW-1:0]         w_last;
    logic                  w_wrap_bad;

    always_comb begin
        w_bytes     = ADDR_WIDTH'(1) << i_size;
        w_total     = (ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size;
        w_mask      = w_total - ADDR_WIDTH'(1);
        w_base      = i_addr & ~w_mask;
        o_next_addr = i_addr;
        w_last      = {1'b0, i_addr};

        case (i_burst)
            BURST_FIXED: begin
                o_next_addr = i_addr;
                w_last      = {1'b0, i_addr};
            end
            BURST_WRAP: begin
                o_next_addr = w_base | ((i_addr + w_bytes) & w_mask);
                w_last      = {1'b0, w_base | w_mask};
            end
            default: begin
                o_next_addr = i_addr + w_bytes;
                w_last      = {1'b0, i_addr} + {1'b0, w_total} - XW'(1);
            end
        endcase

`ifdef AXI_SLV_WRAP_EN
        w_wrap_bad = !((i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15))
                   || ((i_addr & (w_bytes - ADDR_WIDTH'(1))) != '0);
`else
        w_wrap_bad = 1'b1;
`endif

        // Range is checked against the furthest byte the whole burst touches.
        o_err = (32'(i_size) > LSB)
             || (i_burst == 2'b11)
             || ((i_burst == BURST_WRAP) && w_wrap_bad)
             || ((w_last >> LSB) >= XW'(MEM_DEPTH));
    end

endmodule

// File: rtl/axi_slv_mem.sv
// AXI4 memory slave: independent write and read FSMs over one word array.
// WRAP burst support is enabled with the AXI_SLV_WRAP_EN define.
module axi_slv_mem
    import axi_slv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDXW   = $clog2(MEM_DEPTH);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> LSB) < ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[LSB +: IDXW];
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    w_state_t              r_w_state, w_w_next;
    logic                  r_awready, r_wready, r_bvalid;
    logic [ID_WIDTH-1:0]   r_bid, r_wr_id;
    logic [1:0]            r_bresp, r_wr_burst;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [7:0]            r_wr_len, r_wr_cnt;
    logic [2:0]            r_wr_size;
    logic                  r_wr_err;

    logic                  w_aw_hs, w_w_hs, w_b_hs, w_wr_last_beat, w_wlast_err, w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wg_addr, w_wg_next;
    logic [7:0]            w_wg_len;
    logic [2:0]            w_wg_size;
    logic [1:0]            w_wg_burst;
    logic                  w_wg_err;

    assign w_aw_hs        = awvalid && r_awready;
    assign w_w_hs         = wvalid && r_wready;
    assign w_b_hs         = r_bvalid && bready;
    assign w_wr_last_beat = (r_wr_cnt == r_wr_len);
    assign w_wlast_err    = (wlast != w_wr_last_beat);
    assign w_wr_en        = w_w_hs && !r_wr_err && !w_wlast_err && in_range(r_wr_addr);

    // In idle the generator checks the incoming AW payload; otherwise it steps the latched burst.
    assign w_wg_addr  = (r_w_state == W_IDLE) ? awaddr  : r_wr_addr;
    assign w_wg_len   = (r_w_state == W_IDLE) ? awlen   : r_wr_len;
    assign w_wg_size  = (r_w_state == W_IDLE) ? awsize  : r_wr_size;
    assign w_wg_burst = (r_w_state == W_IDLE) ? awburst : r_wr_burst;

    axi_slv_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_wr_gen (
        .i_addr      (w_wg_addr),
        .i_len       (w_wg_len),
        .i_size      (w_wg_size),
        .i_burst     (w_wg_burst),
        .o_next_addr (w_wg_next),
        .o_err       (w_wg_err)
    );

    always_comb begin
        w_w_next = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_aw_hs) w_w_next = W_DATA;
            W_DATA:  if (w_w_hs && w_wr_last_beat) w_w_next = W_RESP;
            W_RESP:  if (w_b_hs) w_w_next = W_IDLE;
            default: w_w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_w_state  <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= RESP_OKAY;
            r_wr_id    <= '0;
            r_wr_addr  <= '0;
            r_wr_len   <= '0;
            r_wr_size  <= '0;
            r_wr_burst <= '0;
            r_wr_cnt   <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            r_w_state <= w_w_next;
            r_awready <= (w_w_next == W_IDLE);
            r_wready  <= (w_w_next == W_DATA);
            r_bvalid  <= (w_w_next == W_RESP);
            if (w_aw_hs) begin
                r_wr_id    <= awid;
                r_wr_addr  <= awaddr;
                r_wr_len   <= awlen;
                r_wr_size  <= awsize;
                r_wr_burst <= awburst;
                r_wr_cnt   <= '0;
                r_wr_err   <= w_wg_err;
            end
            if (w_w_hs) begin
                r_wr_cnt  <= r_wr_cnt + 8'd1;
                r_wr_addr <= w_wg_next;
                r_wr_err  <= r_wr_err || w_wlast_err;
                if (w_wr_last_beat) begin
                    r_bid   <= r_wr_id;
                    r_bresp <= (r_wr_err || w_wlast_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) r_mem[word_idx(r_wr_addr)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t              r_r_state, w_r_next;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp, r_rd_burst;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [7:0]            r_rd_len, r_rd_cnt;
    logic [2:0]            r_rd_size;
    logic                  r_rd_err;

    logic                  w_ar_hs, w_r_hs, w_rd_beat_err;
    logic [ADDR_WIDTH-1:0] w_rg_addr, w_rg_next, w_rd_beat_addr;
    logic [7:0]            w_rg_len;
    logic [2:0]            w_rg_size;
    logic [1:0]            w_rg_burst;
    logic                  w_rg_err;
    logic [DATA_WIDTH-1:0] w_rd_beat_data;

    assign w_ar_hs = arvalid && r_arready;
    assign w_r_hs  = r_rvalid && rready;

    assign w_rg_addr  = (r_r_state == R_IDLE) ? araddr  : r_rd_addr;
    assign w_rg_len   = (r_r_state == R_IDLE) ? arlen   : r_rd_len;
    assign w_rg_size  = (r_r_state == R_IDLE) ? arsize  : r_rd_size;
    assign w_rg_burst = (r_r_state == R_IDLE) ? arburst : r_rd_burst;

    axi_slv_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_rd_gen (
        .i_addr      (w_rg_addr),
        .i_len       (w_rg_len),
        .i_size      (w_rg_size),
        .i_burst     (w_rg_burst),
        .o_next_addr (w_rg_next),
        .o_err       (w_rg_err)
    );

    // The beat to present next: first beat from AR, later beats from the stepped address.
    assign w_rd_beat_addr = (r_r_state == R_IDLE) ? araddr : w_rg_next;
    assign w_rd_beat_err  = ((r_r_state == R_IDLE) ? w_rg_err : r_rd_err) || !in_range(w_rd_beat_addr);
    assign w_rd_beat_data = w_rd_beat_err ? '0 : r_mem[word_idx(w_rd_beat_addr)];

    always_comb begin
        w_r_next = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs) w_r_next = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_r_next = R_IDLE;
            default: w_r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_r_state  <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rid      <= '0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rd_addr  <= '0;
            r_rd_len   <= '0;
            r_rd_size  <= '0;
            r_rd_burst <= '0;
            r_rd_cnt   <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            r_r_state <= w_r_next;
            r_arready <= (w_r_next == R_IDLE);
            r_rvalid  <= (w_r_next == R_DATA);
            if (w_ar_hs) begin
                r_rd_addr  <= araddr;
                r_rd_len   <= arlen;
                r_rd_size  <= arsize;
                r_rd_burst <= arburst;
                r_rd_cnt   <= '0;
                r_rd_err   <= w_rg_err;
                r_rid      <= arid;
                r_rdata    <= w_rd_beat_data;
                r_rresp    <= w_rd_beat_err ? RESP_SLVERR : RESP_OKAY;
                r_rlast    <= (arlen == 8'd0);
            end else if (w_r_hs) begin
                if (r_rlast) begin
                    r_rlast <= 1'b0;
                end else begin
                    r_rd_cnt  <= r_rd_cnt + 8'd1;
                    r_rd_addr <= w_rg_next;
                    r_rdata   <= w_rd_beat_data;
                    r_rresp   <= w_rd_beat_err ? RESP_SLVERR : RESP_OKAY;
                    r_rlast   <= ((r_rd_cnt + 8'd1) == r_rd_len);
                end
            end
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bid     = r_bid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;

endmodule

// File: tb/tb_axi_slv_mem.sv
// Directed self-checking bench for axi_slv_mem (expectations follow AXI_SLV_WRAP_EN).
module tb_axi_slv_mem;
    import axi_slv_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned IW    = 8;
    localparam int unsigned DEPTH = 1024;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [IW-1:0] awid = '0, arid = '0, bid, rid;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [7:0]    awlen = '0, arlen = '0;
    logic [2:0]    awsize = '0, arsize = '0;
    logic [1:0]    awburst = '0, arburst = '0, bresp, rresp;
    logic          awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0;
    logic [DW-1:0] wdata = '0, rdata;
    logic [DW/8-1:0] wstrb = '0;
    logic          bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic          rvalid, rready = 1'b0, rlast;

    int checks = 0;
    int failures = 0;

    axi_slv_mem #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .aclk    (aclk),    .aresetn (aresetn),
        .awid    (awid),    .awaddr  (awaddr),  .awlen   (awlen),
        .awsize  (awsize),  .awburst (awburst), .awvalid (awvalid), .awready (awready),
        .wdata   (wdata),   .wstrb   (wstrb),   .wlast   (wlast),
        .wvalid  (wvalid),  .wready  (wready),
        .bid     (bid),     .bresp   (bresp),   .bvalid  (bvalid),  .bready  (bready),
        .arid    (arid),    .araddr  (araddr),  .arlen   (arlen),
        .arsize  (arsize),  .arburst (arburst), .arvalid (arvalid), .arready (arready),
        .rid     (rid),     .rdata   (rdata),   .rresp   (rresp),   .rlast   (rlast),
        .rvalid  (rvalid),  .rready  (rready)
    );

    always #5 aclk = ~aclk;

    // ---------------- channel drivers (bounded waits) ----------------
    task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic hs;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int n = 0; n <= 50; n++) begin
            hs = awready;
            @(posedge aclk); #1;
            if (hs) break;
            if (n == 50) begin
                checks++; failures++;
                $display("FAIL aw_timeout awready=%b required=1", awready);
            end
        end
        awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic hs;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        for (int n = 0; n <= 50; n++) begin
            hs = arready;
            @(posedge aclk); #1;
            if (hs) break;
            if (n == 50) begin
                checks++; failures++;
                $display("FAIL ar_timeout arready=%b required=1", arready);
            end
        end
        arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        logic hs;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int n = 0; n <= 50; n++) begin
            hs = wready;
            @(posedge aclk); #1;
            if (hs) break;
            if (n == 50) begin
                checks++; failures++;
                $display("FAIL w_timeout wready=%b required=1", wready);
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_get(output logic [7:0] id, output logic [1:0] resp);
        logic got;
        got = 1'b0; id = '0; resp = '0; bready = 1'b1;
        for (int n = 0; n <= 50; n++) begin
            if (bvalid) begin id = bid; resp = bresp; got = 1'b1; end
            @(posedge aclk); #1;
            if (got) break;
            if (n == 50) begin
                checks++; failures++;
                $display("FAIL b_timeout bvalid=%b required=1", bvalid);
            end
        end
        bready = 1'b0;
    endtask

    // Leaves rready high; caller lowers it when done.
    task automatic r_get(output logic [31:0] data, output logic [1:0] resp, output logic last,
                         output logic [7:0] id, output int waits);
        logic got;
        got = 1'b0; data = '0; resp = '0; last = 1'b0; id = '0; waits = 0; rready = 1'b1;
        for (int n = 0; n <= 50; n++) begin
            if (rvalid) begin data = rdata; resp = rresp; last = rlast; id = rid; got = 1'b1; end
            @(posedge aclk); #1;
            if (got) break;
            waits++;
            if (n == 50) begin
                checks++; failures++;
                $display("FAIL r_timeout rvalid=%b required=1", rvalid);
            end
        end
    endtask

    // Beat i carries dbase + i*step; wlast is driven on beat wlast_beat.
    task automatic wr_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [31:0] dbase, input logic [31:0] step,
                            input int wlast_beat, output logic [1:0] resp);
        logic [7:0] bid_got;
        aw_send(id, addr, len, 3'd2, burst);
        for (int i = 0; i <= int'(len); i++) w_beat(dbase + step * i, 4'hF, i == wlast_beat);
        b_get(bid_got, resp);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
            failures++;
            $display("FAIL reset_handshake got=%b required=000000", {awready, wready, bvalid, arready, rvalid, rlast});
        end
        checks++;
        if ({bresp, rresp, bid, rid, rdata} !== '0) begin
            failures++;
            $display("FAIL reset_payload bresp=%h rresp=%h bid=%h rid=%h rdata=%h required all 0", bresp, rresp, bid, rid, rdata);
        end
        @(negedge aclk); aresetn = 1'b1; #1;
        checks++;
        if (awready !== 1'b0) begin
            failures++;
            $display("FAIL awready_before_edge got=%b required=0", awready);
        end
        @(posedge aclk); #1;
        checks++;
        if ({awready, arready} !== 2'b11) begin
            failures++;
            $display("FAIL ready_after_release got=%b required=11", {awready, arready});
        end
    endtask

    task automatic test_incr();
        logic [31:0] d; logic [1:0] resp; logic last; logic [7:0] id; int waits;
        aw_send(8'h05, 32'h10, 8'd3, 3'd2, BURST_INCR);
        checks++;
        if (wready !== 1'b1) begin failures++; $display("FAIL wready_after_aw got=%b required=1", wready); end
        for (int i = 0; i < 4; i++) w_beat(32'hA0 + i, 4'hF, i == 3);
        checks++;
        if (bvalid !== 1'b1) begin failures++; $display("FAIL bvalid_after_wlast got=%b required=1", bvalid); end
        b_get(id, resp);
        checks++;
        if ({id, resp} !== {8'h05, RESP_OKAY}) begin
            failures++; $display("FAIL incr_b bid=%h bresp=%h required 05/0", id, resp);
        end
        ar_send(8'h05, 32'h10, 8'd3, 3'd2, BURST_INCR);
        checks++;
        if (rvalid !== 1'b1) begin failures++; $display("FAIL rvalid_after_ar got=%b required=1", rvalid); end
        for (int i = 0; i < 4; i++) begin
            r_get(d, resp, last, id, waits);
            checks++;
            if ({d, resp, last, id} !== {32'hA0 + i, RESP_OKAY, i == 3, 8'h05} || waits != 0) begin
                failures++;
                $display("FAIL incr_r%0d rdata=%h rresp=%h rlast=%b rid=%h waits=%0d required %h/0/%b/05/0",
                         i, d, resp, last, id, waits, 32'hA0 + i, i == 3);
            end
        end
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_after_last got=%b required=0", rvalid); end
    endtask

    task automatic test_fixed();
        logic [31:0] d; logic [1:0] resp; logic last; logic [7:0] id; int waits;
        wr_burst(8'h01, 32'h40, 8'd0, BURST_INCR, 32'h0, 32'h0, 0, resp);
        aw_send(8'h02, 32'h40, 8'd1, 3'd2, BURST_FIXED);
        w_beat(32'h11, 4'h1, 1'b0);
        w_beat(32'h2200, 4'h2, 1'b1);
        b_get(id, resp);
        checks++;
        if (resp !== RESP_OKAY) begin failures++; $display("FAIL fixed_bresp got=%h required=0", resp); end
        ar_send(8'h02, 32'h40, 8'd0, 3'd2, BURST_INCR);
        r_get(d, resp, last, id, waits);
        rready = 1'b0;
        checks++;
        if ({d, resp, last} !== {32'h00002211, RESP_OKAY, 1'b1}) begin
            failures++; $display("FAIL fixed_read rdata=%h rresp=%h rlast=%b required 00002211/0/1", d, resp, last);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d; logic [1:0] resp; logic last; logic [7:0] id; int waits;
        logic [31:0] exp_d [4];
        logic [1:0]  exp_b;
`ifdef AXI_SLV_WRAP_EN
        exp_d = '{32'hC2, 32'hC3, 32'hC0, 32'hC1};
        exp_b = RESP_OKAY;
`else
        exp_d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        exp_b = RESP_SLVERR;
`endif
        wr_burst(8'h01, 32'h00, 8'd3, BURST_INCR, 32'hB0, 32'h1, 3, resp);
        wr_burst(8'h02, 32'h08, 8'd3, BURST_WRAP, 32'hC0, 32'h1, 3, resp);
        checks++;
        if (resp !== exp_b) begin failures++; $display("FAIL wrap_bresp got=%h required=%h", resp, exp_b); end
        ar_send(8'h03, 32'h00, 8'd3, 3'd2, BURST_INCR);
        for (int i = 0; i < 4; i++) begin
            r_get(d, resp, last, id, waits);
            checks++;
            if (d !== exp_d[i]) begin
                failures++; $display("FAIL wrap_mem%0d got=%h required=%h", i, d, exp_d[i]);
            end
        end
        rready = 1'b0;
    endtask

    task automatic test_oor_read();
        logic [31:0] d; logic [1:0] resp; logic last; logic [7:0] id; int waits;
        ar_send(8'h07, DEPTH * 4, 8'd1, 3'd2, BURST_INCR);
        for (int i = 0; i < 2; i++) begin
            r_get(d, resp, last, id, waits);
            checks++;
            if ({d, resp, last} !== {32'h0, RESP_SLVERR, i == 1}) begin
                failures++;
                $display("FAIL oor_r%0d rdata=%h rresp=%h rlast=%b required 0/2/%b", i, d, resp, last, i == 1);
            end
        end
        rready = 1'b0;
    endtask

    task automatic test_wlast_err_stall();
        logic [31:0] d; logic [1:0] resp; logic last; logic [7:0] id; int waits;
        // Beat 0 rewrites the value already present, so memory must end up unchanged either way.
        wr_burst(8'h03, 32'h10, 8'd3, BURST_INCR, 32'hA0, 32'h100, 1, resp);
        checks++;
        if (resp !== RESP_SLVERR) begin failures++; $display("FAIL wlast_bresp got=%h required=2", resp); end
        ar_send(8'h04, 32'h10, 8'd3, 3'd2, BURST_INCR);
        for (int i = 0; i < 2; i++) begin
            r_get(d, resp, last, id, waits);
            checks++;
            if (d !== 32'hA0 + i) begin failures++; $display("FAIL wlast_mem%0d got=%h required=%h", i, d, 32'hA0 + i); end
        end
        rready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge aclk); #1;
            checks++;
            if ({rvalid, rdata, rlast} !== {1'b1, 32'hA2, 1'b0}) begin
                failures++;
                $display("FAIL stall_c%0d rvalid=%b rdata=%h rlast=%b required 1/000000a2/0", c, rvalid, rdata, rlast);
            end
        end
        for (int i = 2; i < 4; i++) begin
            r_get(d, resp, last, id, waits);
            checks++;
            if ({d, last} !== {32'hA0 + i, i == 3}) begin
                failures++; $display("FAIL wlast_mem%0d got=%h rlast=%b required=%h", i, d, last, 32'hA0 + i);
            end
        end
        rready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d; logic [1:0] resp; logic last; logic [7:0] id; int waits;
        aw_send(8'h04, 32'h60, 8'd3, 3'd2, BURST_INCR);
        w_beat(32'h61, 4'hF, 1'b0);
        w_beat(32'h62, 4'hF, 1'b0);
        wdata = 32'h63; wstrb = 4'hF; wvalid = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b required=00000", {awready, wready, bvalid, arready, rvalid});
        end
        wvalid = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk); aresetn = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if ({awready, bvalid} !== 2'b10) begin
            failures++; $display("FAIL midreset_release awready=%b bvalid=%b required 1/0", awready, bvalid);
        end
        wr_burst(8'h04, 32'h68, 8'd0, BURST_INCR, 32'h99, 32'h0, 0, resp);
        checks++;
        if (resp !== RESP_OKAY) begin failures++; $display("FAIL midreset_bresp got=%h required=0", resp); end
        ar_send(8'h04, 32'h60, 8'd2, 3'd2, BURST_INCR);
        for (int i = 0; i < 3; i++) begin
            r_get(d, resp, last, id, waits);
            checks++;
            if (d !== ((i == 2) ? 32'h99 : 32'h61 + i)) begin
                failures++; $display("FAIL midreset_mem%0d got=%h required=%h", i, d, (i == 2) ? 32'h99 : 32'h61 + i);
            end
        end
        rready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_incr();
        test_fixed();
        test_wrap();
        test_oor_read();
        test_wlast_err_stall();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout required=finish");
        $fatal(1);
    end

endmodule
